// File: rtl/misc_v_pkg.sv
// misc_v_pkg: shared MISC-V decode constants.
// Holds the instruction-class codes found in instr[15:13], the decoded
// immediate class enum, and the width of each class's immediate field.
// Ports: none (package).
package misc_v_pkg;

   // Class codes. R and I use the full 3-bit code; M, Y and J each own
   // two codes and are recognised from instr[15:14] alone.
   localparam logic [2:0] OPC_R     = 3'b000;
   localparam logic [2:0] OPC_I     = 3'b001;
   localparam logic [1:0] OPC_M_MSB = 2'b01;
   localparam logic [1:0] OPC_Y_MSB = 2'b10;
   localparam logic [1:0] OPC_J_MSB = 2'b11;

   // Immediate field widths per class (Y and J share the same field).
   localparam int IMM_W_R  = 4;
   localparam int IMM_W_I  = 4;
   localparam int IMM_W_M  = 7;
   localparam int IMM_W_YJ = 13;

   // Decoded immediate class as presented on imm_type.
   typedef enum logic [2:0] {
      IMM_R = 3'd0,
      IMM_I = 3'd1,
      IMM_M = 3'd2,
      IMM_Y = 3'd3,
      IMM_J = 3'd4
   } imm_type_e;

endpackage

// File: rtl/imm_gen_extract.sv
// imm_extract: combinational class decode and immediate extraction.
// Ports:
//   instr     in  16  low half of the instruction word
//   imm_comb  out 32  sign-extended immediate for the decoded class
//   type_comb out 3   decoded class (imm_type_e encoding)
module imm_extract
   import misc_v_pkg::*;
(
   input  logic [15:0] instr,
   output logic [31:0] imm_comb,
   output logic [2:0]  type_comb
);

   logic [2:0] opc;
   assign opc = instr[15:13];

   // Every class code is defined, so the default arm simply covers the
   // J codes (11x); there is no illegal-opcode path.
   always_comb begin
      imm_comb  = 32'h0000_0000;
      type_comb = IMM_J;
      if (opc == OPC_R) begin
         imm_comb  = {{(32-IMM_W_R){instr[3]}}, instr[3:0]};
         type_comb = IMM_R;
      end else if (opc == OPC_I) begin
         // instr[1:0] sit below the I field and are deliberately dropped.
         imm_comb  = {{(32-IMM_W_I){instr[5]}}, instr[5:2]};
         type_comb = IMM_I;
      end else if (opc[2:1] == OPC_M_MSB) begin
         imm_comb  = {{(32-IMM_W_M){instr[6]}}, instr[6:0]};
         type_comb = IMM_M;
      end else if (opc[2:1] == OPC_Y_MSB) begin
         imm_comb  = {{(32-IMM_W_YJ){instr[12]}}, instr[12:0]};
         type_comb = IMM_Y;
      end else begin
         imm_comb  = {{(32-IMM_W_YJ){instr[12]}}, instr[12:0]};
         type_comb = IMM_J;
      end
   end

endmodule

// File: rtl/imm_gen.sv
// imm_gen: registered immediate generator for the MISC-V execute stage.
// Ports:
//   clk         in  1   system clock, rising edge
//   rst_n       in  1   asynchronous active-low reset
//   instr       in  32  instruction word, only [15:0] significant
//   instr_valid in  1   instr is meaningful this cycle
//   imm         out 32  sign-extended immediate, registered
//   imm_type    out 3   decoded class R=0 I=1 M=2 Y=3 J=4, registered
//   imm_valid   out 1   instr_valid delayed one cycle
module imm_gen
   import misc_v_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic [31:0] imm,
   output logic [2:0]  imm_type,
   output logic        imm_valid
);

   logic [31:0] imm_comb;
   logic [2:0]  type_comb;

   // The upper half of the word belongs to no 16-bit instruction field.
   logic unused_upper;
   assign unused_upper = ^instr[31:16];

   imm_extract u_extract (
      .instr     (instr[15:0]),
      .imm_comb  (imm_comb),
      .type_comb (type_comb)
   );

   // Data registers load every cycle regardless of instr_valid; consumers
   // qualify with imm_valid, so no enable is needed on the data path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm       <= 32'h0000_0000;
         imm_type  <= IMM_R;
         imm_valid <= 1'b0;
      end else begin
         imm       <= imm_comb;
         imm_type  <= type_comb;
         imm_valid <= instr_valid;
      end
   end

endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: directed self-checking bench for imm_gen.
module tb_imm_gen;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] imm;
   logic [2:0]  imm_type;
   logic        imm_valid;

   int check_count = 0;
   int error_count = 0;

   imm_gen dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .imm         (imm),
      .imm_type    (imm_type),
      .imm_valid   (imm_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one word, let it be captured, and settle just after the edge.
   task automatic apply_and_clock(input logic [31:0] word, input logic valid);
      instr       = word;
      instr_valid = valid;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      instr       = 32'h0000_9000;
      instr_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_count++;
      if (imm !== 32'h0 || imm_type !== 3'd0 || imm_valid !== 1'b0) begin
         error_count++;
         $display("[TB] FAIL reset_async: got imm=%h type=%0d valid=%b, want 0/0/0", imm, imm_type, imm_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      check_count++;
      if (imm !== 32'h0 || imm_type !== 3'd0 || imm_valid !== 1'b0) begin
         error_count++;
         $display("[TB] FAIL reset_held: got imm=%h type=%0d valid=%b, want 0/0/0", imm, imm_type, imm_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      apply_and_clock(32'h0000_0001, 1'b1);
      check_count++;
      if (imm !== 32'h0000_0001 || imm_valid !== 1'b1) begin
         error_count++;
         $display("[TB] FAIL reset_release: got imm=%h valid=%b, want 00000001/1", imm, imm_valid);
      end
   endtask

   task automatic test_r_i;
      logic [31:0] words [4];
      logic [31:0] exp_imm [4];
      logic [2:0]  exp_type [4];
      words    = '{32'h0001, 32'h0008, 32'h2004, 32'h2020};
      exp_imm  = '{32'h0000_0001, 32'hFFFF_FFF8, 32'h0000_0001, 32'hFFFF_FFF8};
      exp_type = '{3'd0, 3'd0, 3'd1, 3'd1};
      for (int i = 0; i < 4; i++) begin
         apply_and_clock(words[i], 1'b1);
         check_count++;
         if (imm !== exp_imm[i] || imm_type !== exp_type[i]) begin
            error_count++;
            $display("[TB] FAIL r_i[%0d] instr=%h: got imm=%h type=%0d, want %h/%0d", i, words[i], imm, imm_type, exp_imm[i], exp_type[i]);
         end
      end
   endtask

   task automatic test_m;
      logic [31:0] words [4];
      logic [31:0] exp_imm [4];
      words   = '{32'h4001, 32'h6001, 32'h4040, 32'h6040};
      exp_imm = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFC0, 32'hFFFF_FFC0};
      for (int i = 0; i < 4; i++) begin
         apply_and_clock(words[i], 1'b1);
         check_count++;
         if (imm !== exp_imm[i] || imm_type !== 3'd2) begin
            error_count++;
            $display("[TB] FAIL m[%0d] instr=%h: got imm=%h type=%0d, want %h/2", i, words[i], imm, imm_type, exp_imm[i]);
         end
      end
   endtask

   task automatic test_y_j;
      logic [31:0] words [8];
      logic [31:0] exp_imm [8];
      logic [2:0]  exp_type [8];
      words    = '{32'h8001, 32'hA001, 32'hC001, 32'hE001,
                   32'h9000, 32'hB000, 32'hD000, 32'hF000};
      exp_imm  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                   32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
      exp_type = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd4, 3'd4};
      for (int i = 0; i < 8; i++) begin
         apply_and_clock(words[i], 1'b1);
         check_count++;
         if (imm !== exp_imm[i] || imm_type !== exp_type[i]) begin
            error_count++;
            $display("[TB] FAIL y_j[%0d] instr=%h: got imm=%h type=%0d, want %h/%0d", i, words[i], imm, imm_type, exp_imm[i], exp_type[i]);
         end
      end
   endtask

   task automatic test_isolation;
      apply_and_clock(32'hABCD_0003, 1'b1);
      check_count++;
      if (imm !== 32'h0000_0003 || imm_type !== 3'd0) begin
         error_count++;
         $display("[TB] FAIL iso_upper: got imm=%h type=%0d, want 00000003/0", imm, imm_type);
      end
      apply_and_clock(32'h0000_2003, 1'b1);
      check_count++;
      if (imm !== 32'h0 || imm_type !== 3'd1) begin
         error_count++;
         $display("[TB] FAIL iso_i_low: got imm=%h type=%0d, want 00000000/1", imm, imm_type);
      end
      // Junk outside the M field (bits 12:7) must not leak in.
      apply_and_clock(32'h0000_5F85, 1'b1);
      check_count++;
      if (imm !== 32'h0000_0005 || imm_type !== 3'd2) begin
         error_count++;
         $display("[TB] FAIL iso_m_high: got imm=%h type=%0d, want 00000005/2", imm, imm_type);
      end
   endtask

   task automatic test_invalid;
      apply_and_clock(32'h0000_0008, 1'b0);
      check_count++;
      if (imm !== 32'hFFFF_FFF8 || imm_valid !== 1'b0) begin
         error_count++;
         $display("[TB] FAIL invalid: got imm=%h valid=%b, want FFFFFFF8/0", imm, imm_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] words [3];
      logic [31:0] exp_imm [3];
      logic [2:0]  exp_type [3];
      words    = '{32'h0008, 32'h4040, 32'hD000};
      exp_imm  = '{32'hFFFF_FFF8, 32'hFFFF_FFC0, 32'hFFFF_F000};
      exp_type = '{3'd0, 3'd2, 3'd4};
      for (int i = 0; i < 3; i++) begin
         apply_and_clock(words[i], 1'b1);
         check_count++;
         if (imm !== exp_imm[i] || imm_type !== exp_type[i] || imm_valid !== 1'b1) begin
            error_count++;
            $display("[TB] FAIL b2b[%0d]: got imm=%h type=%0d valid=%b, want %h/%0d/1", i, imm, imm_type, imm_valid, exp_imm[i], exp_type[i]);
         end
      end
   endtask

   task automatic test_reset_midstream;
      apply_and_clock(32'h0000_9000, 1'b1);
      check_count++;
      if (imm !== 32'hFFFF_F000 || imm_valid !== 1'b1) begin
         error_count++;
         $display("[TB] FAIL mid_pre: got imm=%h valid=%b, want FFFFF000/1", imm, imm_valid);
      end
      rst_n = 1'b0;
      #2;
      check_count++;
      if (imm !== 32'h0 || imm_type !== 3'd0 || imm_valid !== 1'b0) begin
         error_count++;
         $display("[TB] FAIL mid_reset: got imm=%h type=%0d valid=%b, want 0/0/0", imm, imm_type, imm_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b1;
      instr       = 32'h0;
      instr_valid = 1'b0;
      test_reset();
      test_r_i();
      test_m();
      test_y_j();
      test_isolation();
      test_invalid();
      test_back_to_back();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
